// File: rtl/image_stream_loader.sv
// Program-image loader: big-endian byte stream (init word, count N, N payload words) into word writes.
// Optional trailer checksum verification is enabled by defining IMAGE_LOADER_CHECKSUM_EN.
module image_stream_loader #(
  parameter int MAX_WORDS = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              img_sel_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              wr_en_o,
  output logic              wr_sel_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              init_we_o,
  output logic [31:0]       init_val_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_INIT,
    S_HDR_CNT,
    S_PAYLOAD,
`ifdef IMAGE_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t            r_state;
  logic [1:0]        r_bcnt;
  logic [23:0]       r_sh;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_lastIdx;
  logic              w_accept;
  logic              w_wordDone;
  logic [31:0]       w_word;
`ifdef IMAGE_LOADER_CHECKSUM_EN
  logic [31:0]       r_sum;
  logic [31:0]       w_sumNext;
`endif

  always_comb begin
    case (r_state)
      S_HDR_INIT, S_HDR_CNT, S_PAYLOAD: byte_ready_o = 1'b1;
`ifdef IMAGE_LOADER_CHECKSUM_EN
      S_CHK:                            byte_ready_o = 1'b1;
`endif
      default:                          byte_ready_o = 1'b0;
    endcase
  end

  // Only the upper three bytes are kept; the fourth arrives with the completing handshake.
  assign w_accept   = byte_valid_i & byte_ready_o;
  assign w_wordDone = w_accept & (r_bcnt == 2'd3);
  assign w_word     = {r_sh, byte_i};
`ifdef IMAGE_LOADER_CHECKSUM_EN
  assign w_sumNext  = r_sum + w_word;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_bcnt     <= '0;
      r_sh       <= '0;
      r_idx      <= '0;
      r_lastIdx  <= '0;
      wr_en_o    <= 1'b0;
      wr_sel_o   <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      init_we_o  <= 1'b0;
      init_val_o <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      wr_en_o   <= 1'b0;
      init_we_o <= 1'b0;
      if (w_accept) begin
        r_sh   <= {r_sh[15:0], byte_i};
        r_bcnt <= r_bcnt + 2'd1;
      end
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            r_state  <= S_HDR_INIT;
            r_bcnt   <= '0;
            r_sh     <= '0;
            r_idx    <= '0;
            wr_sel_o <= img_sel_i;
            busy_o   <= 1'b1;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
            r_sum    <= '0;
`endif
          end
        end
        S_HDR_INIT: begin
          if (w_wordDone) begin
            init_val_o <= w_word;
            init_we_o  <= 1'b1;
            r_state    <= S_HDR_CNT;
`ifdef IMAGE_LOADER_CHECKSUM_EN
            r_sum      <= w_sumNext;
`endif
          end
        end
        S_HDR_CNT: begin
          if (w_wordDone) begin
`ifdef IMAGE_LOADER_CHECKSUM_EN
            r_sum <= w_sumNext;
`endif
            if (w_word > 32'(MAX_WORDS)) begin
              r_state <= S_ERR;
              err_o   <= 1'b1;
              busy_o  <= 1'b0;
            end else if (w_word == 32'd0) begin
`ifdef IMAGE_LOADER_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_state <= S_DONE;
              done_o  <= 1'b1;
              busy_o  <= 1'b0;
`endif
            end else begin
              r_lastIdx <= ADDR_W'(w_word - 32'd1);
              r_idx     <= '0;
              r_state   <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (w_wordDone) begin
            wr_en_o   <= 1'b1;
            wr_addr_o <= r_idx;
            wr_data_o <= w_word;
            r_idx     <= r_idx + 1'b1;
`ifdef IMAGE_LOADER_CHECKSUM_EN
            r_sum     <= w_sumNext;
            if (r_idx == r_lastIdx) r_state <= S_CHK;
`else
            if (r_idx == r_lastIdx) begin
              r_state <= S_DONE;
              done_o  <= 1'b1;
              busy_o  <= 1'b0;
            end
`endif
          end
        end
`ifdef IMAGE_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_wordDone) begin
            busy_o <= 1'b0;
            if (w_word == r_sum) begin
              r_state <= S_DONE;
              done_o  <= 1'b1;
            end else begin
              r_state <= S_ERR;
              err_o   <= 1'b1;
            end
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_stream_loader.sv
// Scoreboard bench for image_stream_loader: stimulus pushes expected strobes, a monitor pops and compares.
// Checksum scenarios run when IMAGE_LOADER_CHECKSUM_EN is defined for both bench and design.
module tb_image_stream_loader;

  localparam int MAX_WORDS = 1024;
  localparam int ADDR_W    = 10;
`ifdef IMAGE_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic              img_sel_i;
  logic [7:0]        byte_i;
  logic              byte_valid_i;
  logic              byte_ready_o;
  logic              wr_en_o;
  logic              wr_sel_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [31:0]       wr_data_o;
  logic              init_we_o;
  logic [31:0]       init_val_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  image_stream_loader #(.MAX_WORDS(MAX_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .img_sel_i(img_sel_i),
    .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
    .wr_en_o(wr_en_o), .wr_sel_o(wr_sel_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .init_we_o(init_we_o), .init_val_o(init_val_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          isInit;
    logic [31:0] addr;
    logic [31:0] data;
    bit          sel;
    bit          isLast;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    exp_t e;
    if (init_we_o) begin
      if (expQ.size() == 0) checkOutput("unexpected_init", init_val_o, 32'hxxxxxxxx);
      else begin
        e = expQ.pop_front();
        checkOutput("init_kind", 32'(e.isInit), 32'd1);
        checkOutput("init_val", init_val_o, e.data);
      end
    end
    if (wr_en_o) begin
      if (expQ.size() == 0) checkOutput("unexpected_write", 32'(wr_addr_o), 32'hxxxxxxxx);
      else begin
        e = expQ.pop_front();
        checkOutput("wr_kind", 32'(e.isInit), 32'd0);
        checkOutput("wr_addr", 32'(wr_addr_o), e.addr);
        checkOutput("wr_data", wr_data_o, e.data);
        checkOutput("wr_sel", 32'(wr_sel_o), 32'(e.sel));
        if (e.isLast) begin
          checkOutput("last_done", 32'(done_o), 32'd1);
          checkOutput("last_busy", 32'(busy_o), 32'd0);
          checkOutput("last_ready", 32'(byte_ready_o), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic sendByte(input logic [7:0] b, input bit gapped);
    bit accepted = 1'b0;
    bit rdy;
    if (gapped) begin
      repeat ($urandom_range(0, 2)) begin
        byte_valid_i = 1'b0;
        byte_i = 8'($urandom);
        if ($urandom_range(0, 3) == 0) start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
      end
    end
    byte_valid_i = 1'b1;
    byte_i = b;
    for (int c = 0; c < 20 && !accepted; c++) begin
      @(negedge clk_i);
      rdy = byte_ready_o;
      @(posedge clk_i); #1;
      if (rdy) accepted = 1'b1;
    end
    byte_valid_i = 1'b0;
    if (!accepted) checkOutput("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic sendWord(input logic [31:0] w, input bit gapped);
    for (int k = 3; k >= 0; k--) sendByte(w[8*k +: 8], gapped);
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 20 && expQ.size() != 0; c++) @(negedge clk_i);
    checkOutput("drain_pending", 32'(expQ.size()), 32'd0);
  endtask

  task automatic offerIdleBytes();
    byte_valid_i = 1'b1;
    byte_i = 8'hA5;
    repeat (3) begin
      @(negedge clk_i);
      checkOutput("idle_ready", 32'(byte_ready_o), 32'd0);
    end
    @(posedge clk_i); #1;
    byte_valid_i = 1'b0;
  endtask

  // Reference model: expectations follow directly from the image contents.
  task automatic applyStimulus(input logic [31:0] words[$], input bit sel, input bit gapped,
                               input int stopAfter, input bit badTrailer);
    logic [31:0] n;
    logic [31:0] sum;
    bit          oversize;
    bit          expErr;
    int          sendCount;
    exp_t        e;
    @(posedge clk_i); #1;
    img_sel_i = sel;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    img_sel_i = ~sel;
    checkOutput("start_busy", 32'(busy_o), 32'd1);
    checkOutput("start_err", 32'(err_o), 32'd0);
    checkOutput("start_done", 32'(done_o), 32'd0);
    n = words[1];
    oversize = n > 32'(MAX_WORDS);
    e.isInit = 1'b1; e.addr = '0; e.data = words[0]; e.sel = sel; e.isLast = 1'b0;
    expQ.push_back(e);
    sendWord(words[0], gapped);
    sendWord(words[1], gapped);
    sum = words[0] + words[1];
    if (!oversize) begin
      sendCount = (stopAfter < 0) ? int'(n) : stopAfter;
      for (int i = 0; i < sendCount; i++) begin
        e.isInit = 1'b0; e.addr = 32'(i); e.data = words[i+2]; e.sel = sel;
        e.isLast = (i == int'(n) - 1) && !CHK_EN;
        expQ.push_back(e);
        sendWord(words[i+2], gapped);
        sum += words[i+2];
      end
      if (CHK_EN && stopAfter < 0) sendWord(sum + 32'(badTrailer), gapped);
    end
    waitDrain();
    if (stopAfter < 0) begin
      expErr = oversize || (CHK_EN && badTrailer);
      repeat (2) @(negedge clk_i);
      checkOutput("end_done", 32'(done_o), 32'(!expErr));
      checkOutput("end_err", 32'(err_o), 32'(expErr));
      checkOutput("end_busy", 32'(busy_o), 32'd0);
      checkOutput("end_ready", 32'(byte_ready_o), 32'd0);
      checkOutput("end_init_val", init_val_o, words[0]);
      checkOutput("end_wr_sel", 32'(wr_sel_o), 32'(sel));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy_o), 32'd0);
    checkOutput({tag, "_done"}, 32'(done_o), 32'd0);
    checkOutput({tag, "_err"}, 32'(err_o), 32'd0);
    checkOutput({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
    checkOutput({tag, "_wr_en"}, 32'(wr_en_o), 32'd0);
    checkOutput({tag, "_init_we"}, 32'(init_we_o), 32'd0);
    checkOutput({tag, "_init_val"}, init_val_o, 32'd0);
    checkOutput({tag, "_wr_addr"}, 32'(wr_addr_o), 32'd0);
    checkOutput({tag, "_wr_data"}, wr_data_o, 32'd0);
    checkOutput({tag, "_wr_sel"}, 32'(wr_sel_o), 32'd0);
  endtask

  initial begin
    logic [31:0] img[$];
    logic [31:0] big[$];
    rst_i = 1'b1; start_i = 1'b0; img_sel_i = 1'b0; byte_i = '0; byte_valid_i = 1'b0;
    repeat (2) @(posedge clk_i); #1;
    checkAllZero("reset");
    rst_i = 1'b0;

    $display("[TB] instruction image");
    img = '{32'h00000000, 32'h00000002, 32'h12345678, 32'hDEADBEEF};
    applyStimulus(img, 1'b0, 1'b0, -1, 1'b0);

    $display("[TB] zero count");
    img = '{32'h00000400, 32'h00000000};
    applyStimulus(img, 1'b1, 1'b0, -1, 1'b0);
    offerIdleBytes();

    $display("[TB] oversize count");
    img = '{32'h00000010, 32'h00000401};
    applyStimulus(img, 1'b0, 1'b0, -1, 1'b0);
    offerIdleBytes();

    $display("[TB] random images, ungapped then gapped with start pokes");
    for (int t = 0; t < 4; t++) begin
      img.delete();
      img.push_back($urandom);
      img.push_back(32'($urandom_range(1, 6)));
      for (int i = 0; i < int'(img[1]); i++) img.push_back($urandom);
      applyStimulus(img, 1'($urandom_range(0, 1)), 1'b0, -1, 1'b0);
      applyStimulus(img, 1'($urandom_range(0, 1)), 1'b1, -1, 1'b0);
    end

    $display("[TB] maximum count");
    big = '{32'h0000BEEF, 32'(MAX_WORDS)};
    for (int i = 0; i < MAX_WORDS; i++) big.push_back($urandom);
    applyStimulus(big, 1'b1, 1'b0, -1, 1'b0);

    $display("[TB] reset mid-payload");
    img = '{32'h00001000, 32'h00000008};
    for (int i = 0; i < 8; i++) img.push_back($urandom);
    applyStimulus(img, 1'b1, 1'b0, 5, 1'b0);
    checkOutput("midload_busy", 32'(busy_o), 32'd1);
    @(posedge clk_i); #3;
    rst_i = 1'b1;
    #1;
    checkAllZero("async_reset");
    repeat (2) @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (10) @(posedge clk_i);
    checkOutput("post_reset_busy", 32'(busy_o), 32'd0);
    applyStimulus(img, 1'b0, 1'b1, -1, 1'b0);

    if (CHK_EN) begin
      $display("[TB] checksum trailer");
      img = '{32'h00000000, 32'h00000001, 32'h00000005};
      applyStimulus(img, 1'b1, 1'b0, -1, 1'b0);
      applyStimulus(img, 1'b1, 1'b0, -1, 1'b1);
      img = '{32'h00000020, 32'h00000000};
      applyStimulus(img, 1'b0, 1'b1, -1, 1'b0);
    end

    repeat (3) @(negedge clk_i);
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_stream_loader.md
Name: image_stream_loader

Overview:
- Hardware consumer of the program-image format used by the CPU test flow.
- Format: a big-endian 32-bit word stream. Word0 is the init value (PC for the instruction image, $sp for the data image). Word1 is the word count N. N payload words follow.
- Accepts bytes over a valid/ready handshake, reassembles words, and drives a word-write port into instruction or data memory plus an init-value strobe.
- Holds the CPU off (busy_o) until loading completes.

Parameters:
- MAX_WORDS, 1024, largest legal N; larger N is an error.
- ADDR_W, 10, width of wr_addr_o (word index); must satisfy 2^ADDR_W >= MAX_WORDS.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- start_i  in  1  one-cycle pulse; begins a load when idle, done or error.
- img_sel_i  in  1  image type: 0 = instruction, 1 = data; sampled on an accepted start_i.
- byte_i  in  8  stream byte, MSB of each word first.
- byte_valid_i  in  1  byte_i is valid.
- byte_ready_o  out  1  loader can accept a byte.
- wr_en_o  out  1  one-cycle memory write strobe.
- wr_sel_o  out  1  latched img_sel_i.
- wr_addr_o  out  ADDR_W  payload word index, 0..N-1.
- wr_data_o  out  32  assembled word; data memory stores it little-endian (byte i*4+0 = bits 7:0).
- init_we_o  out  1  one-cycle strobe; init_val_o is valid.
- init_val_o  out  32  word0 of the image.
- busy_o  out  1  a load is in progress.
- done_o  out  1  load completed; sticky.
- err_o  out  1  load aborted; sticky.

Behaviour:
- Reset: state IDLE; every output 0; byte counter, word counter and shift register cleared. Reset asserted mid-load abandons the load with no further writes.
- States: IDLE, HDR_INIT, HDR_CNT, PAYLOAD, DONE, ERR.
- Byte accept: occurs on byte_valid_i & byte_ready_o.
  - byte_ready_o = 1 only in HDR_INIT, HDR_CNT and PAYLOAD.
  - Each accepted byte shifts in: sh <= {sh[23:0], byte_i}.
  - A 2-bit byte counter wraps 3 -> 0; the fourth byte completes the word.
  - Bytes with byte_valid_i low are not consumed and leave all state unchanged.
- IDLE/DONE/ERR + start_i: go to HDR_INIT; clear done_o and err_o; latch wr_sel_o; set busy_o = 1 from the next cycle. start_i in any other state is ignored.
- HDR_INIT word complete: in the next cycle, init_val_o <= word and init_we_o pulses for 1 cycle; go to HDR_CNT.
- HDR_CNT word complete:
  - N > MAX_WORDS: go to ERR; err_o = 1, busy_o = 0.
  - N == 0: go to DONE; done_o = 1, busy_o = 0.
  - Otherwise latch N, clear the word index, go to PAYLOAD.
- PAYLOAD word complete: in the next cycle wr_en_o = 1 for 1 cycle, with wr_addr_o = index and wr_data_o = word; then index increments.
  - Latency from accepting the 4th byte to wr_en_o is exactly 1 cycle.
  - Back-to-back words are supported; at most one write per 4 accepted bytes.
- Last payload word (index == N-1): state becomes DONE in the same cycle that wr_en_o pulses. done_o rises in that cycle, busy_o falls, byte_ready_o drops.
- wr_addr_o and wr_data_o hold their last values between strobes. init_val_o holds until the next successful HDR_INIT.
- Bytes offered while in IDLE, DONE or ERR are not accepted (byte_ready_o = 0).
- Counter widths: the word index wraps only through reset or start_i; N is compared as 32-bit unsigned.

Optional Feature:
- Macro: IMAGE_LOADER_CHECKSUM_EN.
- Defined:
  - A trailer word follows the payload; state CHK sits between PAYLOAD and DONE.
  - The checksum is the 32-bit wrapping sum of all prior words (init, count, payload).
  - Match: go to DONE.
  - Mismatch: go to ERR with err_o = 1.
  - The trailer is never written to memory.
  - With N == 0, the trailer follows the count word directly.
- Undefined: no CHK state, no trailer, no adder logic.

Test Plan:
- Instruction image: start_i with img_sel_i = 0, stream 00000000, 00000002, 12345678, DEADBEEF.
  - init_we_o with 0x00000000.
  - wr_en_o at addr 0 with 0x12345678, then addr 1 with 0xDEADBEEF.
  - done_o = 1 in the same cycle as the second write; busy_o = 0.
- Count of 0: stream 00000400, 00000000 -> init_val_o = 0x400, no wr_en_o, done_o = 1.
- Oversize: N = 0x00000401 with MAX_WORDS = 1024 -> err_o = 1, byte_ready_o = 0, no writes; a following start_i clears err_o.
- Gapped handshake: random byte_valid_i gaps; start_i pulsed mid-load -> words and addresses identical to the ungapped run; start_i ignored.
- Reset mid-payload: rst_i asserted after 5 of 8 payload words -> all outputs 0 asynchronously, no further wr_en_o; a fresh load then completes correctly.
- IMAGE_LOADER_CHECKSUM_EN defined: image 0, 1, 5 with trailer 6 -> done_o = 1; same image with trailer 7 -> err_o = 1, with the payload write still issued.
